// File: rtl/iob_eth_host_ctrl.sv
// rtl/iob_eth_host_ctrl.sv - bus master that runs the Ethernet core's register port for TX and RX frames
// Optional RX CRC residue check is built when IOB_ETH_HOST_CRC_CHK_EN is defined.
module iob_eth_host_ctrl #(
   parameter int ADDR_W         = 12,
   parameter int STATUS_ADDR    = 0,
   parameter int SEND_ADDR      = 1,
   parameter int RCVACK_ADDR    = 2,
   parameter int TX_NBYTES_ADDR = 5,
   parameter int RX_NBYTES_ADDR = 6,
   parameter int CRC_ADDR       = 7,
   parameter int POLL_GAP       = 8
) (
   input  logic              clk,
   input  logic              rst_int,
   input  logic              tx_start,
   input  logic [10:0]       tx_len,
   input  logic [7:0]        tx_byte,
   input  logic              tx_byte_valid,
   output logic              tx_byte_ready,
   output logic              tx_busy,
   output logic              tx_done,
   input  logic              rx_en,
   input  logic [10:0]       rx_len,
   output logic [7:0]        rx_byte,
   output logic              rx_byte_valid,
   input  logic              rx_byte_ready,
   output logic              rx_last,
   output logic              rx_crc_err,
   output logic              eth_valid,
   output logic              eth_wstrb,
   output logic [ADDR_W-1:0] eth_addr,
   output logic [31:0]       eth_wdata,
   input  logic [31:0]       eth_rdata,
   input  logic              eth_ready
);

   localparam logic [3:0] ST_INIT    = 4'd0;
   localparam logic [3:0] ST_IDLE    = 4'd1;
   localparam logic [3:0] ST_TX_WR   = 4'd2;
   localparam logic [3:0] ST_TX_LEN  = 4'd3;
   localparam logic [3:0] ST_TX_POLL = 4'd4;
   localparam logic [3:0] ST_TX_SEND = 4'd5;
   localparam logic [3:0] ST_RX_POLL = 4'd6;
   localparam logic [3:0] ST_RX_RD   = 4'd7;
   localparam logic [3:0] ST_RX_ACK  = 4'd8;
`ifdef IOB_ETH_HOST_CRC_CHK_EN
   localparam logic [3:0]  ST_RX_CRC   = 4'd9;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
`endif

   localparam logic [ADDR_W-1:0] BUF_BASE = {1'b1, {(ADDR_W-1){1'b0}}};
   localparam logic [15:0]       GAP      = 16'(POLL_GAP);

   logic [3:0]        state_q, state_d;
   logic              sub_q, sub_d;
   logic [10:0]       cnt_q, cnt_d;
   logic [10:0]       len_q, len_d;
   logic [10:0]       rxlen_q, rxlen_d;
   logic [15:0]       gap_q, gap_d;
   logic              pend_q, pend_d;
   logic              valid_q, valid_d;
   logic              wstrb_q, wstrb_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [7:0]        rxb_q, rxb_d;
   logic              rxv_q, rxv_d;
   logic              rxl_q, rxl_d;
`ifdef IOB_ETH_HOST_CRC_CHK_EN
   logic              crc_q, crc_d;
`endif

   logic              req, req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp;

   assign resp = pend_q & eth_ready;

   always_comb begin
      state_d       = state_q;
      sub_d         = sub_q;
      cnt_d         = cnt_q;
      len_d         = len_q;
      rxlen_d       = rxlen_q;
      gap_d         = gap_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      rxb_d         = rxb_q;
      rxv_d         = rxv_q;
      rxl_d         = rxl_q;
`ifdef IOB_ETH_HOST_CRC_CHK_EN
      crc_d         = crc_q;
`endif
      req           = 1'b0;
      req_wr        = 1'b0;
      req_addr      = '0;
      req_wdata     = '0;
      tx_byte_ready = 1'b0;

      case (state_q)
         ST_INIT: begin
            if (!sub_q) begin
               if (resp) begin
                  if (eth_rdata[15] && eth_rdata[0]) begin
                     sub_d   = 1'b1;
                     rxlen_d = rx_len;
                  end else begin
                     gap_d = GAP;
                  end
               end else if (!pend_q) begin
                  if (gap_q != 16'd0) begin
                     gap_d = gap_q - 16'd1;
                  end else begin
                     req      = 1'b1;
                     req_addr = ADDR_W'(STATUS_ADDR);
                  end
               end
            end else begin
               if (resp) begin
                  state_d = ST_IDLE;
                  sub_d   = 1'b0;
               end else if (!pend_q) begin
                  req       = 1'b1;
                  req_wr    = 1'b1;
                  req_addr  = ADDR_W'(RX_NBYTES_ADDR);
                  req_wdata = {21'd0, rxlen_q};
               end
            end
         end

         ST_IDLE: begin
            if (tx_start) begin
               // A zero-length frame never touches the core; just acknowledge it.
               if (tx_len == 11'd0) begin
                  done_d = 1'b1;
               end else begin
                  len_d   = tx_len;
                  cnt_d   = 11'd0;
                  busy_d  = 1'b1;
                  state_d = ST_TX_WR;
               end
            end else if (rx_en) begin
               sub_d   = 1'b0;
               state_d = ST_RX_POLL;
            end
         end

         ST_TX_WR: begin
            if (resp && cnt_q == len_q) begin
               state_d = ST_TX_LEN;
            end else if (!pend_q && cnt_q != len_q && tx_byte_valid) begin
               tx_byte_ready = 1'b1;
               req           = 1'b1;
               req_wr        = 1'b1;
               req_addr      = BUF_BASE | ADDR_W'(cnt_q);
               req_wdata     = {24'd0, tx_byte};
               cnt_d         = cnt_q + 11'd1;
            end
         end

         ST_TX_LEN: begin
            if (resp) begin
               gap_d   = 16'd0;
               state_d = ST_TX_POLL;
            end else if (!pend_q) begin
               req       = 1'b1;
               req_wr    = 1'b1;
               req_addr  = ADDR_W'(TX_NBYTES_ADDR);
               req_wdata = {21'd0, len_q};
            end
         end

         ST_TX_POLL: begin
            if (resp) begin
               if (eth_rdata[0]) state_d = ST_TX_SEND;
               else              gap_d   = GAP;
            end else if (!pend_q) begin
               if (gap_q != 16'd0) begin
                  gap_d = gap_q - 16'd1;
               end else begin
                  req      = 1'b1;
                  req_addr = ADDR_W'(STATUS_ADDR);
               end
            end
         end

         ST_TX_SEND: begin
            if (resp) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (!pend_q) begin
               req       = 1'b1;
               req_wr    = 1'b1;
               req_addr  = ADDR_W'(SEND_ADDR);
               req_wdata = 32'd1;
            end
         end

         ST_RX_POLL: begin
            if (!sub_q) begin
               if (resp) begin
                  if (eth_rdata[1]) begin
                     cnt_d   = 11'd0;
                     state_d = (rxlen_q == 11'd0) ? ST_RX_ACK : ST_RX_RD;
                  end else begin
                     sub_d = 1'b1;
                     gap_d = GAP;
                  end
               end else if (!pend_q) begin
                  req      = 1'b1;
                  req_addr = ADDR_W'(STATUS_ADDR);
               end
            end else if (gap_q != 16'd0) begin
               gap_d = gap_q - 16'd1;
            end else begin
               sub_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end

         ST_RX_RD: begin
            // Buffer read data is only valid in the ready cycle, so capture it there.
            if (resp) begin
               rxb_d = eth_rdata[7:0];
               rxv_d = 1'b1;
               rxl_d = (cnt_q == rxlen_q - 11'd1);
               cnt_d = cnt_q + 11'd1;
`ifdef IOB_ETH_HOST_CRC_CHK_EN
               if (cnt_q == 11'd0) crc_d = 1'b0;
`endif
            end else if (rxv_q) begin
               if (rx_byte_ready) begin
                  rxv_d = 1'b0;
                  rxl_d = 1'b0;
                  if (rxl_q) begin
`ifdef IOB_ETH_HOST_CRC_CHK_EN
                     state_d = ST_RX_CRC;
`else
                     state_d = ST_RX_ACK;
`endif
                  end
               end
            end else if (!pend_q) begin
               req      = 1'b1;
               req_addr = BUF_BASE | ADDR_W'(cnt_q);
            end
         end

`ifdef IOB_ETH_HOST_CRC_CHK_EN
         ST_RX_CRC: begin
            if (resp) begin
               crc_d   = (eth_rdata != CRC_RESIDUE);
               state_d = ST_RX_ACK;
            end else if (!pend_q) begin
               req      = 1'b1;
               req_addr = ADDR_W'(CRC_ADDR);
            end
         end
`endif

         ST_RX_ACK: begin
            if (resp) begin
               state_d = ST_IDLE;
            end else if (!pend_q) begin
               req       = 1'b1;
               req_wr    = 1'b1;
               req_addr  = ADDR_W'(RCVACK_ADDR);
               req_wdata = 32'd1;
            end
         end

         default: state_d = ST_INIT;
      endcase

      valid_d = 1'b0;
      pend_d  = pend_q & ~eth_ready;
      addr_d  = addr_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      if (req) begin
         valid_d = 1'b1;
         pend_d  = 1'b1;
         addr_d  = req_addr;
         wstrb_d = req_wr;
         wdata_d = req_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         state_q <= ST_INIT;
         sub_q   <= 1'b0;
         cnt_q   <= '0;
         len_q   <= '0;
         rxlen_q <= '0;
         gap_q   <= '0;
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         wstrb_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rxb_q   <= '0;
         rxv_q   <= 1'b0;
         rxl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         rxlen_q <= rxlen_d;
         gap_q   <= gap_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         wstrb_q <= wstrb_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rxb_q   <= rxb_d;
         rxv_q   <= rxv_d;
         rxl_q   <= rxl_d;
      end
   end

`ifdef IOB_ETH_HOST_CRC_CHK_EN
   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) crc_q <= 1'b0;
      else         crc_q <= crc_d;
   end
   assign rx_crc_err = crc_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{eth_rdata[31:16], eth_rdata[14:8], 32'(CRC_ADDR)};
   assign rx_crc_err = 1'b0;
`endif

   assign eth_valid     = valid_q;
   assign eth_wstrb     = wstrb_q;
   assign eth_addr      = addr_q;
   assign eth_wdata     = wdata_q;
   assign tx_busy       = busy_q;
   assign tx_done       = done_q;
   assign rx_byte       = rxb_q;
   assign rx_byte_valid = rxv_q;
   assign rx_last       = rxl_q;

endmodule

// File: tb/tb_iob_eth_host_ctrl.sv
// tb/tb_iob_eth_host_ctrl.sv - directed table-driven bench with a behavioural Ethernet core model
module tb_iob_eth_host_ctrl;
`ifdef IOB_ETH_HOST_CRC_CHK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_int = 1'b1;
   logic        tx_start = 1'b0;
   logic [10:0] tx_len = 11'd0;
   logic [7:0]  tx_byte = 8'd0;
   logic        tx_byte_valid = 1'b0;
   logic        tx_byte_ready, tx_busy, tx_done;
   logic        rx_en = 1'b0;
   logic [10:0] rx_len = 11'd64;
   logic [7:0]  rx_byte;
   logic        rx_byte_valid, rx_last, rx_crc_err;
   logic        rx_byte_ready = 1'b0;
   logic        eth_valid, eth_wstrb;
   logic [11:0] eth_addr;
   logic [31:0] eth_wdata;
   logic [31:0] eth_rdata;
   logic        eth_ready;

   always #5 clk = ~clk;

   iob_eth_host_ctrl dut (
      .clk(clk), .rst_int(rst_int),
      .tx_start(tx_start), .tx_len(tx_len), .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid),
      .tx_byte_ready(tx_byte_ready), .tx_busy(tx_busy), .tx_done(tx_done),
      .rx_en(rx_en), .rx_len(rx_len), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
      .rx_byte_ready(rx_byte_ready), .rx_last(rx_last), .rx_crc_err(rx_crc_err),
      .eth_valid(eth_valid), .eth_wstrb(eth_wstrb), .eth_addr(eth_addr), .eth_wdata(eth_wdata),
      .eth_rdata(eth_rdata), .eth_ready(eth_ready)
   );

   // Core model: one-cycle completion, write log, status/buffer/CRC reads.
   logic [31:0] status_val = 32'd0;
   logic [31:0] crc_val = 32'hC704DD7B;
   logic [7:0]  rx_buf [16];
   logic [11:0] wr_addr_q [$];
   logic [31:0] wr_data_q [$];
   int          stat_reads = 0;

   always @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         eth_ready <= 1'b0;
         eth_rdata <= 32'd0;
      end else begin
         eth_ready <= eth_valid;
         if (eth_valid) begin
            if (eth_wstrb) begin
               wr_addr_q.push_back(eth_addr);
               wr_data_q.push_back(eth_wdata);
            end else if (eth_addr[11]) begin
               eth_rdata <= {24'd0, rx_buf[eth_addr[3:0]]};
            end else if (eth_addr == 12'd0) begin
               eth_rdata <= status_val;
               stat_reads++;
            end else if (eth_addr == 12'd7) begin
               eth_rdata <= crc_val;
            end else begin
               eth_rdata <= 32'hDEADBEEF;
            end
         end
      end
   end

   int          vlong = 0, stab_err = 0, done_cnt = 0, rdy_cnt = 0, rdy_bad = 0;
   logic        vprev = 1'b0;
   logic [11:0] vaddr = 12'd0;

   always @(negedge clk) begin
      if (eth_valid && vprev) vlong++;
      vprev = eth_valid;
      if (eth_valid) vaddr = eth_addr;
      if (eth_ready && eth_addr != vaddr) stab_err++;
      if (tx_done) done_cnt++;
   end

   always @(negedge clk) begin
      #2;
      if (tx_byte_ready) begin
         rdy_cnt++;
         if (!tx_byte_valid) rdy_bad++;
      end
   end

   int n_pass = 0, n_chk = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic outs_nonzero();
      return |{eth_valid, eth_wstrb, eth_addr, eth_wdata, tx_busy, tx_done, tx_byte_ready,
               rx_byte, rx_byte_valid, rx_last, rx_crc_err};
   endfunction

   typedef struct {
      int          tc;
      logic [11:0] addr;
      logic [31:0] data;
   } wr_vec_t;

   typedef struct {
      int          frame;
      logic [7:0]  b;
      logic        last;
   } rx_vec_t;

   wr_vec_t tx_tab [11];
   rx_vec_t rx_tab [6];

   task automatic do_reset(input logic [10:0] rl);
      @(negedge clk);
      rst_int = 1'b1;
      rx_len  = rl;
      #1;
      chk("reset_outputs_zero", {31'd0, outs_nonzero()}, 32'd0);
      @(negedge clk);
      wr_addr_q.delete();
      wr_data_q.delete();
      stat_reads = 0;
      rst_int = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int budget);
      int k = 0;
      while (wr_addr_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (wr_addr_q.size() < n) chk("write_wait_timeout", wr_addr_q.size(), n);
   endtask

   task automatic feed_byte(input logic [7:0] b, output bit ok);
      int n = 0;
      tx_byte = b;
      tx_byte_valid = 1'b1;
      ok = 1'b0;
      while (!ok && n < 100) begin
         #1;
         ok = tx_byte_ready;
         @(negedge clk);
         n++;
      end
      tx_byte_valid = 1'b0;
   endtask

   task automatic run_tx(input int tc, input logic [10:0] len, input logic [31:0] payload, input int gap);
      int  base_rdy, base_done, base_stat, n, j;
      bit  ok;
      wr_addr_q.delete();
      wr_data_q.delete();
      status_val = 32'd0;
      base_rdy  = rdy_cnt;
      base_done = done_cnt;
      @(negedge clk);
      tx_start = 1'b1;
      tx_len   = len;
      @(negedge clk);
      tx_start = 1'b0;
      chk($sformatf("tx%0d_busy_set", tc), {31'd0, tx_busy}, 32'd1);
      for (int i = 0; i < int'(len); i++) begin
         if (tc == 1 && i == 1) begin
            tx_start = 1'b1;
            tx_len   = 11'd7;
            @(negedge clk);
            tx_start = 1'b0;
         end
         feed_byte(payload[8*i +: 8], ok);
         if (!ok) chk($sformatf("tx%0d_accept_timeout", tc), 32'd0, 32'd1);
         repeat (gap) @(negedge clk);
      end
      wait_writes(int'(len) + 1, 200);
      base_stat = stat_reads;
      n = 0;
      while (stat_reads < base_stat + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      status_val = 32'h00008001;
      n = 0;
      while (done_cnt == base_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk($sformatf("tx%0d_done_pulses", tc), done_cnt - base_done, 32'd1);
      chk($sformatf("tx%0d_busy_clear", tc), {31'd0, tx_busy}, 32'd0);
      chk($sformatf("tx%0d_accepts", tc), rdy_cnt - base_rdy, {21'd0, len});
      chk($sformatf("tx%0d_write_count", tc), wr_addr_q.size(), int'(len) + 2);
      j = 0;
      foreach (tx_tab[k]) begin
         if (tx_tab[k].tc == tc) begin
            chk($sformatf("tx%0d_wr%0d_addr", tc, j),
                (j < wr_addr_q.size()) ? {20'd0, wr_addr_q[j]} : 32'hFFFFFFFF, {20'd0, tx_tab[k].addr});
            chk($sformatf("tx%0d_wr%0d_data", tc, j),
                (j < wr_data_q.size()) ? wr_data_q[j] : 32'hFFFFFFFF, tx_tab[k].data);
            j++;
         end
      end
   endtask

   task automatic run_rx(input int frame, input logic [31:0] crc);
      logic [7:0] got_b [3];
      logic       got_l [3];
      int         idx = 0, hold = 0, n = 0, j = 0;
      wr_addr_q.delete();
      wr_data_q.delete();
      crc_val    = crc;
      status_val = 32'h00000002;
      rx_en      = 1'b1;
      while (idx < 3 && n < 400) begin
         @(negedge clk);
         n++;
         #1;
         if (rx_byte_valid) begin
            rx_en = 1'b0;
            if (idx == 1 && hold < 5) begin
               rx_byte_ready = 1'b0;
               hold++;
            end else begin
               rx_byte_ready = 1'b1;
               got_b[idx] = rx_byte;
               got_l[idx] = rx_last;
               idx++;
            end
         end else begin
            rx_byte_ready = 1'b0;
         end
      end
      @(negedge clk);
      rx_byte_ready = 1'b0;
      rx_en = 1'b0;
      chk($sformatf("rx%0d_byte_count", frame), idx, 32'd3);
      foreach (rx_tab[k]) begin
         if (rx_tab[k].frame == frame && j < idx) begin
            chk($sformatf("rx%0d_byte%0d", frame, j), {24'd0, got_b[j]}, {24'd0, rx_tab[k].b});
            chk($sformatf("rx%0d_last%0d", frame, j), {31'd0, got_l[j]}, {31'd0, rx_tab[k].last});
            j++;
         end
      end
      wait_writes(1, 100);
      repeat (4) @(negedge clk);
      chk($sformatf("rx%0d_ack_count", frame), wr_addr_q.size(), 32'd1);
      chk($sformatf("rx%0d_ack_addr", frame),
          (wr_addr_q.size() > 0) ? {20'd0, wr_addr_q[0]} : 32'hFFFFFFFF, 32'd2);
      chk($sformatf("rx%0d_crc_err", frame), {31'd0, rx_crc_err},
          {31'd0, (CRC_EN && frame == 1)});
   endtask

   initial begin
      bit ok;
      int n, base_stat, base_done;

      tx_tab[0]  = '{0, 12'h800, 32'h000000AA};
      tx_tab[1]  = '{0, 12'h801, 32'h000000BB};
      tx_tab[2]  = '{0, 12'h802, 32'h000000CC};
      tx_tab[3]  = '{0, 12'h803, 32'h000000DD};
      tx_tab[4]  = '{0, 12'h005, 32'h00000004};
      tx_tab[5]  = '{0, 12'h001, 32'h00000001};
      tx_tab[6]  = '{1, 12'h800, 32'h00000001};
      tx_tab[7]  = '{1, 12'h801, 32'h00000002};
      tx_tab[8]  = '{1, 12'h802, 32'h00000003};
      tx_tab[9]  = '{1, 12'h005, 32'h00000003};
      tx_tab[10] = '{1, 12'h001, 32'h00000001};
      rx_tab[0]  = '{0, 8'h11, 1'b0};
      rx_tab[1]  = '{0, 8'h22, 1'b0};
      rx_tab[2]  = '{0, 8'h33, 1'b1};
      rx_tab[3]  = '{1, 8'h44, 1'b0};
      rx_tab[4]  = '{1, 8'h55, 1'b0};
      rx_tab[5]  = '{1, 8'h66, 1'b1};
      foreach (rx_buf[i]) rx_buf[i] = 8'h00;

      // Init: 20 polls of 0x0000, then 0x8001 -> single RX_NBYTES write.
      status_val = 32'd0;
      do_reset(11'd64);
      n = 0;
      while (stat_reads < 20 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      status_val = 32'h00008001;
      wait_writes(1, 100);
      repeat (20) @(negedge clk);
      chk("init_status_polls", stat_reads, 32'd21);
      chk("init_write_count", wr_addr_q.size(), 32'd1);
      chk("init_write_addr", (wr_addr_q.size() > 0) ? {20'd0, wr_addr_q[0]} : 32'hFFFFFFFF, 32'd6);
      chk("init_write_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hFFFFFFFF, 32'd64);

      // tx_len = 0: done next cycle, no bus traffic.
      wr_addr_q.delete();
      wr_data_q.delete();
      @(negedge clk);
      tx_start = 1'b1;
      tx_len   = 11'd0;
      @(negedge clk);
      tx_start = 1'b0;
      chk("tx_len0_done", {31'd0, tx_done}, 32'd1);
      chk("tx_len0_busy", {31'd0, tx_busy}, 32'd0);
      @(negedge clk);
      chk("tx_len0_done_single", {31'd0, tx_done}, 32'd0);
      repeat (5) @(negedge clk);
      chk("tx_len0_no_traffic", wr_addr_q.size(), 32'd0);

      run_tx(0, 11'd4, 32'hDDCCBBAA, 0);
      run_tx(1, 11'd3, 32'h00030201, 3);

      // RX frames need rx_len=3, which is only sampled in INIT.
      status_val = 32'h00008001;
      do_reset(11'd3);
      wait_writes(1, 100);
      chk("rx_init_len", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hFFFFFFFF, 32'd3);
      repeat (3) @(negedge clk);
      rx_buf[0] = 8'h11; rx_buf[1] = 8'h22; rx_buf[2] = 8'h33;
      run_rx(0, 32'hC704DD7B);
      rx_buf[0] = 8'h44; rx_buf[1] = 8'h55; rx_buf[2] = 8'h66;
      run_rx(1, 32'h12345678);

      // Reset during TX_WR at byte 2 of 10.
      @(negedge clk);
      tx_start = 1'b1;
      tx_len   = 11'd10;
      @(negedge clk);
      tx_start = 1'b0;
      feed_byte(8'h50, ok);
      chk("rst_tx_byte0", {31'd0, ok}, 32'd1);
      feed_byte(8'h51, ok);
      chk("rst_tx_byte1", {31'd0, ok}, 32'd1);
      tx_byte = 8'h52;
      tx_byte_valid = 1'b1;
      #1;
      base_done = done_cnt;
      status_val = 32'd0;
      rst_int = 1'b1;
      #1;
      chk("rst_mid_outputs_zero", {31'd0, outs_nonzero()}, 32'd0);
      tx_byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      wr_addr_q.delete();
      wr_data_q.delete();
      base_stat = stat_reads;
      rst_int = 1'b0;
      repeat (50) @(negedge clk);
      chk("rst_no_writes", wr_addr_q.size(), 32'd0);
      chk("rst_reenters_init_polling", {31'd0, stat_reads > base_stat}, 32'd1);
      chk("rst_no_tx_done", done_cnt - base_done, 32'd0);
      chk("rst_busy_clear", {31'd0, tx_busy}, 32'd0);

      chk("eth_valid_single_cycle", vlong, 32'd0);
      chk("eth_addr_stable", stab_err, 32'd0);
      chk("tx_ready_without_valid", rdy_bad, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
